systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 37 +++
 rtl/systolic_feeder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/systolic_pkg.sv
// Shared state encoding, operand slot indices and default widths for the
// 2x2 systolic multiplier controller.
package systolic_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_FEED0   = 3'd2,
        ST_FEED1   = 3'd3,
        ST_FEED2   = 3'd4,
        ST_FEED3   = 3'd5,
        ST_CAPTURE = 3'd6,
        ST_RESULT  = 3'd7
    } state_e;

    // Slot positions inside the latched operand vector.
    localparam int OP_A11  = 0;
    localparam int OP_A12  = 1;
    localparam int OP_A21  = 2;
    localparam int OP_A22  = 3;
    localparam int OP_B11  = 4;
    localparam int OP_B12  = 5;
    localparam int OP_B21  = 6;
    localparam int OP_B22  = 7;
    localparam int NUM_OPS = 8;

    // Slot positions inside the captured result vector.
    localparam int RES_11  = 0;
    localparam int RES_12  = 1;
    localparam int RES_21  = 2;
    localparam int RES_22  = 3;
    localparam int NUM_RES = 4;

endpackage

// File: rtl/systolic_feeder.sv
// Controller for a 2x2 output-stationary systolic array: latches A and B,
// clears the array, feeds skewed rows/columns, then captures and holds C.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a11,
    input  logic signed [DATA_W-1:0] a12,
    input  logic signed [DATA_W-1:0] a21,
    input  logic signed [DATA_W-1:0] a22,
    input  logic signed [DATA_W-1:0] b11,
    input  logic signed [DATA_W-1:0] b12,
    input  logic signed [DATA_W-1:0] b21,
    input  logic signed [DATA_W-1:0] b22,
    output logic                     arr_clr,
    output logic signed [DATA_W-1:0] a1X,
    output logic signed [DATA_W-1:0] a2X,
    output logic signed [DATA_W-1:0] bX1,
    output logic signed [DATA_W-1:0] bX2,
    output logic                     push11,
    output logic                     pushedge,
    output logic                     push22,
    input  logic signed [ACC_W-1:0]  c11,
    input  logic signed [ACC_W-1:0]  c12,
    input  logic signed [ACC_W-1:0]  c21,
    input  logic signed [ACC_W-1:0]  c22,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  r11,
    output logic signed [ACC_W-1:0]  r12,
    output logic signed [ACC_W-1:0]  r21,
    output logic signed [ACC_W-1:0]  r22
);

    state_e                          state_q, state_d;
    logic [NUM_OPS-1:0][DATA_W-1:0]  op_q, op_d;
    logic [NUM_RES-1:0][ACC_W-1:0]   res_q, res_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    // Feeds and pushes decode purely from the registered state and operands,
    // so the array sees glitch-free, cycle-aligned skewed wavefronts.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        arr_clr   = 1'b0;
        a1X       = '0;
        a2X       = '0;
        bX1       = '0;
        bX2       = '0;
        push11    = 1'b0;
        pushedge  = 1'b0;
        push22    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d[OP_A11] = a11;
                    op_d[OP_A12] = a12;
                    op_d[OP_A21] = a21;
                    op_d[OP_A22] = a22;
                    op_d[OP_B11] = b11;
                    op_d[OP_B12] = b12;
                    op_d[OP_B21] = b21;
                    op_d[OP_B22] = b22;
                    state_d      = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                arr_clr = 1'b1;
                state_d = ST_FEED0;
            end
            ST_FEED0: begin
                a1X     = op_q[OP_A11];
                bX1     = op_q[OP_B11];
                push11  = 1'b1;
                state_d = ST_FEED1;
            end
            ST_FEED1: begin
                a1X      = op_q[OP_A12];
                bX1      = op_q[OP_B21];
                a2X      = op_q[OP_A21];
                bX2      = op_q[OP_B12];
                push11   = 1'b1;
                pushedge = 1'b1;
                state_d  = ST_FEED2;
            end
            ST_FEED2: begin
                a2X      = op_q[OP_A22];
                bX2      = op_q[OP_B22];
                pushedge = 1'b1;
                push22   = 1'b1;
                state_d  = ST_FEED3;
            end
            ST_FEED3: begin
                // PE22 consumes operands forwarded inside the array; no new feeds.
                push22  = 1'b1;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_d[RES_11] = c11;
                res_d[RES_12] = c12;
                res_d[RES_21] = c21;
                res_d[RES_22] = c22;
                state_d       = ST_RESULT;
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign r11 = res_q[RES_11];
    assign r12 = res_q[RES_12];
    assign r21 = res_q[RES_21];
    assign r22 = res_q[RES_22];

endmodule
